// File: rtl/pe_array_sequencer.sv
// Anti-diagonal wavefront sequencer for a linear Pair-HMM systolic PE array.
// Optional per-step watchdog enabled by defining PE_SEQ_WATCHDOG_EN.
module pe_array_sequencer #(
    parameter int NUM_PE      = 8,
    parameter int LEN_W       = 8,
    parameter int WDOG_CYCLES = 1023
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [LEN_W-1:0]  read_len,
    input  logic [LEN_W-1:0]  hap_len,
    input  logic [NUM_PE-1:0] pe_done,
    input  logic [NUM_PE-1:0] pe_stall,
    input  logic              out_ready,
    output logic [NUM_PE-1:0] pe_enable,
    output logic [NUM_PE-1:0] set_tb_special,
    output logic              advance,
    output logic              global_stall,
    output logic [LEN_W-1:0]  hap_idx,
    output logic              result_valid,
    output logic [LEN_W-1:0]  result_col,
    output logic              busy,
    output logic              job_done,
    output logic              error
);

    // One extra bit so the last step index R+H-2 never wraps.
    localparam int SW = LEN_W + 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        ADV,
        DONE
    } state_t;

    state_t             state_q, state_d;
    logic [SW-1:0]      step_q, step_d;
    logic [LEN_W-1:0]   rlen_q, rlen_d;
    logic [LEN_W-1:0]   hlen_q, hlen_d;
    logic               error_q, error_d;

    logic [NUM_PE-1:0]  active_mask;
    logic               in_step;
    logic               all_done;
    logic               last_active;
    logic [SW-1:0]      last_step_idx;

`ifdef PE_SEQ_WATCHDOG_EN
    localparam int WDOG_W = $clog2(WDOG_CYCLES + 1);
    logic [WDOG_W-1:0]  wdog_q, wdog_d;
`else
    logic               unused_pe_stall;
    assign unused_pe_stall = ^{pe_stall, 32'(WDOG_CYCLES)};
`endif

    always_comb begin
        active_mask = '0;
        for (int k = 0; k < NUM_PE; k++) begin
            active_mask[k] = (SW'(k) < {1'b0, rlen_q}) &&
                             (step_q >= SW'(k)) &&
                             ((step_q - SW'(k)) < {1'b0, hlen_q});
        end
    end

    assign in_step   = (state_q == RUN) || (state_q == ADV);
    assign pe_enable = in_step ? active_mask : '0;

    always_comb begin
        set_tb_special = '0;
        last_active    = 1'b0;
        for (int k = 0; k < NUM_PE; k++) begin
            set_tb_special[k] = pe_enable[k] && (step_q == SW'(k));
            if ({1'b0, rlen_q} == SW'(k + 1)) begin
                last_active = pe_enable[k];
            end
        end
    end

    assign all_done      = ((pe_done & pe_enable) == pe_enable) && (|pe_enable);
    assign last_step_idx = {1'b0, rlen_q} + {1'b0, hlen_q} - SW'(2);

    assign hap_idx      = (in_step && (step_q < {1'b0, hlen_q})) ? step_q[LEN_W-1:0] : '0;
    assign advance      = (state_q == ADV);
    assign result_valid = advance && last_active;
    assign result_col   = result_valid ? (step_q[LEN_W-1:0] - rlen_q + LEN_W'(1)) : '0;
    assign busy         = in_step;
    assign job_done     = (state_q == DONE);
    assign error        = error_q;

    // pe_stall never freezes the array; only a blocked last-row result does.
    assign global_stall = (state_q == RUN) && all_done && last_active && !out_ready;

    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        rlen_d  = rlen_q;
        hlen_d  = hlen_q;
        error_d = 1'b0;
`ifdef PE_SEQ_WATCHDOG_EN
        wdog_d  = (state_q == RUN) ? wdog_q : '0;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    if ((read_len == '0) || (hap_len == '0) ||
                        ({1'b0, read_len} > SW'(NUM_PE))) begin
                        error_d = 1'b1;
                    end else begin
                        rlen_d  = read_len;
                        hlen_d  = hap_len;
                        step_d  = '0;
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                if (all_done) begin
                    if (!last_active || out_ready) begin
                        state_d = ADV;
                    end
                end
`ifdef PE_SEQ_WATCHDOG_EN
                else if (!(|pe_stall)) begin
                    if (int'(wdog_q) >= WDOG_CYCLES - 1) begin
                        error_d = 1'b1;
                        state_d = IDLE;
                    end else begin
                        wdog_d = wdog_q + WDOG_W'(1);
                    end
                end
`endif
            end
            ADV: begin
                if (step_q == last_step_idx) begin
                    state_d = DONE;
                end else begin
                    step_d  = step_q + SW'(1);
                    state_d = RUN;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            step_q  <= '0;
            rlen_q  <= '0;
            hlen_q  <= '0;
            error_q <= 1'b0;
`ifdef PE_SEQ_WATCHDOG_EN
            wdog_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            rlen_q  <= rlen_d;
            hlen_q  <= hlen_d;
            error_q <= error_d;
`ifdef PE_SEQ_WATCHDOG_EN
            wdog_q  <= wdog_d;
`endif
        end
    end

endmodule
